keypad_scan: RTL and testbench

- Scans a 4x4 matrix keypad and outputs one debounced key code per press, plus a release pulse.
- Columns are driven one at a time (active-low, one-cold) and rows are read back, one column per dwell slot. This is the input-side counterpart of the multiplexed seven-segment display driver.
- Sits between the board keypad pins and the time/count-setting logic.

---
 rtl/keypad_scan_if.sv | 33 +++
 rtl/keypad_scan.sv | 237 +++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-event bundle between the matrix scanner and the keypad pins / setting logic.
interface keypad_if;
    localparam int unsigned N_ROW = 4;
    localparam int unsigned N_COL = 4;
    localparam int unsigned KEY_W = 4;

    logic [N_ROW-1:0] i_row;
    logic [N_COL-1:0] o_col;
    logic [KEY_W-1:0] o_key;
    logic             o_key_valid;
    logic             o_key_held;
    logic             o_key_rel;

    // Scanner side: reads rows, drives columns and key events.
    modport master (
        input  i_row,
        output o_col,
        output o_key,
        output o_key_valid,
        output o_key_held,
        output o_key_rel
    );

    // Pin / consumer side: drives rows, observes columns and key events.
    modport slave (
        output i_row,
        input  o_col,
        input  o_key,
        input  o_key_valid,
        input  o_key_held,
        input  o_key_rel
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-cold column drive, per-frame row capture,
// frame-level debounce of a single press and of its release.
module keypad_scan #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);

    localparam int unsigned N_ROW  = 4;
    localparam int unsigned N_COL  = 4;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned N_BIT  = N_ROW * N_COL;
    localparam int unsigned ACC_W  = N_ROW * (N_COL - 1);
    localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [N_ROW-1:0] row_meta;
    logic [N_ROW-1:0] row_sync;

    // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= kp.i_row;
            row_sync <= row_meta;
        end
    end

    // ------------------------------------------------------------------
    // Column dwell timer
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;

    assign tick_c = (tick_cnt == TICK_LAST);

    // Free-running dwell counter, wraps after SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Column drive and frame capture
    // ------------------------------------------------------------------
    logic [1:0]       col_idx;
    logic [1:0]       col_nxt_c;
    logic [N_COL-1:0] col_q;
    logic [ACC_W-1:0] acc_q;       // pressed (active-high) rows of cols 0..2
    logic             frame_end_c;
    logic [N_BIT-1:0] frame_c;     // bit index = col*4 + row

    assign col_nxt_c   = col_idx + 2'd1;
    assign frame_end_c = tick_c && (col_idx == 2'd3);
    assign frame_c     = {~row_sync, acc_q};

    // Sample the current column on tick, then step to the next column.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx <= 2'd0;
            col_q   <= 4'b1110;
            acc_q   <= '0;
        end else if (tick_c) begin
            case (col_idx)
                2'd0:    acc_q[3:0]  <= ~row_sync;
                2'd1:    acc_q[7:4]  <= ~row_sync;
                2'd2:    acc_q[11:8] <= ~row_sync;
                default: ;
            endcase
            col_idx <= col_nxt_c;
            col_q   <= ~(4'b0001 << col_nxt_c);
        end
    end

    // ------------------------------------------------------------------
    // Frame classification: none / single(key) / multi
    // ------------------------------------------------------------------
    logic [1:0]       hit_cnt_c;   // saturates at 2
    logic [KEY_W-1:0] hit_key_c;
    logic             is_single_c;
    logic             is_none_c;

    // Count pressed bits in the frame and remember the first one's key code.
    always_comb begin
        hit_cnt_c = 2'd0;
        hit_key_c = '0;
        for (int k = 0; k < 16; k++) begin
            if (frame_c[k[3:0]]) begin
                if (hit_cnt_c == 2'd0) begin
                    hit_key_c = {k[1:0], k[3:2]};
                end
                if (hit_cnt_c != 2'd2) begin
                    hit_cnt_c = hit_cnt_c + 2'd1;
                end
            end
        end
        is_none_c   = (hit_cnt_c == 2'd0);
        is_single_c = (hit_cnt_c == 2'd1);
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [KEY_W-1:0] cand_q,  cand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [KEY_W-1:0] key_q,   key_d;
    logic             valid_q, valid_d;
    logic             held_q,  held_d;
    logic             rel_q,   rel_d;

    assign cnt_inc_c = cnt_q + CNT_ONE;

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            rel_q   <= rel_d;
        end
    end

    // Next-state and output decode, evaluated only at frame end.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;
        rel_d   = 1'b0;

        if (frame_end_c) begin
            case (state_q)
                S_IDLE: begin
                    if (is_single_c) begin
                        cand_d  = hit_key_c;
                        cnt_d   = CNT_ONE;
                        state_d = S_DEBOUNCE;
                    end
                end

                S_DEBOUNCE: begin
                    if (is_single_c) begin
                        if (hit_key_c == cand_q) begin
                            cnt_d = cnt_inc_c;
                            if (cnt_inc_c == CNT_DONE) begin
                                key_d   = cand_q;
                                valid_d = 1'b1;
                                held_d  = 1'b1;
                                state_d = S_PRESSED;
                            end
                        end else begin
                            cand_d = hit_key_c;
                            cnt_d  = CNT_ONE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end

                S_PRESSED: begin
                    // Multi-key and other-key frames keep the press; no rollover.
                    if (is_none_c) begin
                        cnt_d   = CNT_ONE;
                        state_d = S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    if (is_single_c && (hit_key_c == key_q)) begin
                        state_d = S_PRESSED;
                    end else if (is_single_c) begin
                        held_d  = 1'b0;
                        rel_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c == CNT_DONE) begin
                            held_d  = 1'b0;
                            rel_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign kp.o_col       = col_q;
    assign kp.o_key       = key_q;
    assign kp.o_key_valid = valid_q;
    assign kp.o_key_held  = held_q;
    assign kp.o_key_rel   = rel_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural keypad matrix model.
module tb_keypad_scan;

    localparam int unsigned SCAN_DIV     = 8;
    localparam int unsigned DEBOUNCE_CNT = 3;
    localparam int          FRAME        = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;     // bit k set => key k (row k/4, col k%4) pressed
    logic [3:0]  row_drv;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int vcount      = 0;
    int rcount      = 0;
    int last_valid  = -1;
    int last_rel    = -1;
    int s           = 0;

    keypad_if kp();

    keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_drv = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (keys[k[3:0]] && !kp.o_col[k[1:0]]) begin
                row_drv[k[3:2]] = 1'b0;
            end
        end
    end

    assign kp.i_row = row_drv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        vcount     = 0;
        rcount     = 0;
        last_valid = -1;
        last_rel   = -1;
    endtask

    // Advance n cycles, checking the column drive and tallying pulses.
    task automatic run_cycles(input int n);
        logic [3:0] exp_col;
        int         ci;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            ci      = (cyc / SCAN_DIV) % 4;
            exp_col = 4'b1111;
            exp_col[ci[1:0]] = 1'b0;
            check("o_col", 32'(kp.o_col), 32'(exp_col));
            if (kp.o_key_valid === 1'b1) begin
                vcount++;
                last_valid = cyc;
            end
            if (kp.o_key_rel === 1'b1) begin
                rcount++;
                last_rel = cyc;
            end
        end
    endtask

    task automatic run_frames(input int n);
        run_cycles(n * FRAME);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        check("rst_col",   32'(kp.o_col),       32'h0000_000E);
        check("rst_key",   32'(kp.o_key),       32'd0);
        check("rst_valid", 32'(kp.o_key_valid), 32'd0);
        check("rst_held",  32'(kp.o_key_held),  32'd0);
        check("rst_rel",   32'(kp.o_key_rel),   32'd0);
        clear_tally();
    endtask

    initial begin
        // Reset and idle scan
        keys = '0;
        do_reset(2);
        run_frames(2);
        check("idle_valid_cnt", 32'(vcount), 32'd0);
        check("idle_rel_cnt",   32'(rcount), 32'd0);
        check("idle_key",       32'(kp.o_key),      32'd0);
        check("idle_held",      32'(kp.o_key_held), 32'd0);

        // Hold key 9 (r2,c1) from a frame start
        clear_tally();
        s    = cyc;
        keys = 16'h0200;
        run_frames(3);
        check("press9_valid_cnt", 32'(vcount), 32'd1);
        check("press9_valid_at",  32'(last_valid), 32'(s + 3 * FRAME));
        check("press9_key",       32'(kp.o_key), 32'd9);
        check("press9_held",      32'(kp.o_key_held), 32'd1);
        clear_tally();
        run_frames(2);
        check("hold9_valid_cnt", 32'(vcount), 32'd0);
        check("hold9_held",      32'(kp.o_key_held), 32'd1);

        // Release key 9 for 3 frames
        clear_tally();
        s    = cyc;
        keys = '0;
        run_frames(3);
        check("rel9_rel_cnt", 32'(rcount), 32'd1);
        check("rel9_rel_at",  32'(last_rel), 32'(s + 3 * FRAME));
        check("rel9_held",    32'(kp.o_key_held), 32'd0);
        check("rel9_key",     32'(kp.o_key), 32'd9);
        check("rel9_valid",   32'(vcount), 32'd0);

        // Bounce: 1 on, 1 off, 2 on, off
        clear_tally();
        keys = 16'h0200; run_frames(1);
        keys = '0;       run_frames(1);
        keys = 16'h0200; run_frames(2);
        keys = '0;       run_frames(2);
        check("bounce_valid_cnt", 32'(vcount), 32'd0);
        check("bounce_held",      32'(kp.o_key_held), 32'd0);

        // Press 9, release 2 frames, re-press: stays held, no pulses
        keys = 16'h0200; run_frames(3);
        check("re_press_held", 32'(kp.o_key_held), 32'd1);
        clear_tally();
        keys = '0;       run_frames(2);
        keys = 16'h0200; run_frames(2);
        check("re_valid_cnt", 32'(vcount), 32'd0);
        check("re_rel_cnt",   32'(rcount), 32'd0);
        check("re_held",      32'(kp.o_key_held), 32'd1);
        keys = '0;       run_frames(3);
        check("re_final_rel", 32'(rcount), 32'd1);

        // In release, a different single key ends the press at once
        keys = 16'h0200; run_frames(3);
        clear_tally();
        s    = cyc;
        keys = '0;       run_frames(1);
        keys = 16'h0400; run_frames(1);
        check("relother_rel_cnt", 32'(rcount), 32'd1);
        check("relother_rel_at",  32'(last_rel), 32'(s + 2 * FRAME));
        check("relother_held",    32'(kp.o_key_held), 32'd0);
        check("relother_key",     32'(kp.o_key), 32'd9);
        keys = '0;       run_frames(1);

        // Keys 0 and 15 together from idle
        clear_tally();
        keys = 16'h8001; run_frames(5);
        check("multi_valid_cnt", 32'(vcount), 32'd0);
        check("multi_held",      32'(kp.o_key_held), 32'd0);
        check("multi_key",       32'(kp.o_key), 32'd9);
        keys = '0;       run_frames(1);

        // Key 5 pressed, then 6 added, then only 6
        clear_tally();
        s    = cyc;
        keys = 16'h0020; run_frames(3);
        check("press5_valid_at", 32'(last_valid), 32'(s + 3 * FRAME));
        check("press5_key",      32'(kp.o_key), 32'd5);
        clear_tally();
        keys = 16'h0060; run_frames(2);
        keys = 16'h0040; run_frames(2);
        check("add6_key",       32'(kp.o_key), 32'd5);
        check("add6_valid_cnt", 32'(vcount), 32'd0);
        check("add6_rel_cnt",   32'(rcount), 32'd0);
        check("add6_held",      32'(kp.o_key_held), 32'd1);
        keys = '0;       run_frames(3);
        check("rel5_rel_cnt", 32'(rcount), 32'd1);
        check("rel5_held",    32'(kp.o_key_held), 32'd0);

        // Reset in the middle of debouncing key 3 (r0,c3)
        clear_tally();
        keys = 16'h0008; run_frames(2);
        check("pre_rst_valid_cnt", 32'(vcount), 32'd0);
        do_reset(1);
        run_frames(2);
        check("post_rst_valid_cnt2", 32'(vcount), 32'd0);
        run_frames(1);
        check("post_rst_valid_cnt3", 32'(vcount), 32'd1);
        check("post_rst_valid_at",   32'(last_valid), 32'(3 * FRAME));
        check("post_rst_key",        32'(kp.o_key), 32'd3);
        check("post_rst_held",       32'(kp.o_key_held), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
